// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: sequential shift-add-3 binary-to-BCD plus digit scanning.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens leading-zero hundreds/tens digits.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value,
  input  logic [1:0]  level,
  input  logic        show_level,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t        state_reg, state_next;
  logic [7:0]    last_value_reg, lat_reg, shreg_reg;
  logic [11:0]   acc_reg, acc_adj, bcd_reg;
  logic [2:0]    cnt_reg;
  logic [PW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    nib;
  logic          dark;
  logic [6:0]    seg_pat;
  logic [6:0]    seg_reg;
  logic [3:0]    an_reg;

  // Per-nibble +3 correction applied before each shift.
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ? acc_reg[gi*4 +: 4] + 4'd3
                                                            : acc_reg[gi*4 +: 4];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (value != last_value_reg) state_next = SHIFT;
      SHIFT:   if (cnt_reg == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_value_reg <= 8'd0;
      lat_reg        <= 8'd0;
      shreg_reg      <= 8'd0;
      acc_reg        <= 12'd0;
      cnt_reg        <= 3'd0;
      bcd_reg        <= 12'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (value != last_value_reg) begin
          lat_reg   <= value;
          shreg_reg <= value;
          acc_reg   <= 12'd0;
          cnt_reg   <= 3'd0;
        end
        SHIFT: begin
          {acc_reg, shreg_reg} <= {acc_adj[10:0], shreg_reg, 1'b0};
          cnt_reg              <= cnt_reg + 3'd1;
        end
        DONE: begin
          bcd_reg        <= acc_reg;
          last_value_reg <= lat_reg;
        end
        default: ;
      endcase
    end
  end

  // Scan prescaler: the digit index advances once every SCAN_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      idx_reg   <= 2'd0;
    end else if (presc_reg == PW'(SCAN_DIV - 1)) begin
      presc_reg <= '0;
      idx_reg   <= idx_reg + 2'd1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  always_comb begin
    nib  = 4'd0;
    dark = 1'b0;
    case (idx_reg)
      2'd0: nib = bcd_reg[3:0];
      2'd1: begin
        nib = bcd_reg[7:4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        dark = (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0);
`else
        dark = 1'b0;
`endif
      end
      2'd2: begin
        nib = bcd_reg[11:8];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        dark = (bcd_reg[11:8] == 4'd0);
`else
        dark = 1'b0;
`endif
      end
      default: begin
        nib  = {2'b00, level} + 4'd1;
        dark = !show_level || (level == 2'd3);
      end
    endcase
  end

  always_comb begin
    seg_pat = 7'h7F;
    case (nib)
      4'd0: seg_pat = 7'b1000000;
      4'd1: seg_pat = 7'b1111001;
      4'd2: seg_pat = 7'b0100100;
      4'd3: seg_pat = 7'b0110000;
      4'd4: seg_pat = 7'b0011001;
      4'd5: seg_pat = 7'b0010010;
      4'd6: seg_pat = 7'b0000010;
      4'd7: seg_pat = 7'b1111000;
      4'd8: seg_pat = 7'b0000000;
      4'd9: seg_pat = 7'b0010000;
      default: seg_pat = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= 7'h7F;
      an_reg  <= 4'hF;
    end else if (blank || dark) begin
      seg_reg <= 7'h7F;
      an_reg  <= 4'hF;
    end else begin
      seg_reg <= seg_pat;
      an_reg  <= ~(4'b0001 << idx_reg);
    end
  end

  assign seg  = seg_reg;
  assign an   = an_reg;
  assign bcd  = bcd_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed and random values against a decimal/scan-time model.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk, rst_n;
  logic [7:0]  value;
  logic [1:0]  level;
  logic        show_level, blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [11:0] bcd;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int edges;
  int model_last;
  logic [11:0] model_bcd;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .level(level), .show_level(show_level),
    .blank(blank), .seg(seg), .an(an), .bcd(bcd), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges seen since reset release; the lit digit follows from this alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic chk_display(input string tag);
    int idx;
    int d;
    bit lit;
    logic [3:0] ea;
    logic [6:0] es;
    idx = ((edges - 1) / SCAN_DIV) % 4;
    lit = 1'b1;
    d   = 0;
    case (idx)
      0: d = model_bcd[3:0];
      1: begin
        d = model_bcd[7:4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lit = (model_bcd[11:4] != 0);
`endif
      end
      2: begin
        d = model_bcd[11:8];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lit = (model_bcd[11:8] != 0);
`endif
      end
      default: begin
        d   = int'(level) + 1;
        lit = show_level && (level != 2'd3);
      end
    endcase
    if (blank || !lit) begin
      ea = 4'hF;
      es = 7'h7F;
    end else begin
      ea = ~(4'b0001 << idx);
      es = SEG_TAB[d];
    end
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_seg"}, 32'(seg), 32'(es));
  endtask

  task automatic sweep(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_display(tag);
    end
  endtask

  // Called at the negedge just before edge N; counts busy cycles and checks the result.
  task automatic wait_conv(input int v, input string tag);
    int n = 0;
    int guard = 0;
    @(negedge clk);
    while (busy === 1'b1 && guard < 40) begin
      n++;
      guard++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, 32'(n), (v == model_last) ? 32'd0 : 32'd9);
    if (v != model_last) begin
      model_last = v;
      model_bcd  = to_bcd(v);
    end
    chk({tag, "_bcd"}, 32'(bcd), 32'(model_bcd));
    $display("conv %s value=%0d bcd=%03h busy_cycles=%0d", tag, v, bcd, n);
  endtask

  task automatic convert(input int v, input int lvl, input bit sl, input string tag);
    value      = 8'(v);
    level      = 2'(lvl);
    show_level = sl;
    wait_conv(v, tag);
    sweep(tag, 4 * SCAN_DIV + 1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; value = 8'd0; level = 2'd0; show_level = 1'b0; blank = 1'b0;
    model_last = 0;
    model_bcd  = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_bcd", 32'(bcd), 32'h000);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    sweep("scan", 4 * SCAN_DIV);

    convert(173, 2, 1'b1, "v173");
    convert(255, 1, 1'b1, "v255");
    convert(0, 0, 1'b0, "v0");
    for (int i = 0; i < 6; i++)
      convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'($urandom), "rand");
    convert(77, 3, 1'b1, "v77");

    // Value changes during the third busy cycle; the first conversion must finish untouched.
    value = 8'd10;
    repeat (3) @(negedge clk);
    value = 8'd200;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk("mid_first_bcd", 32'(bcd), 32'h010);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(busy === 1'b0 && bcd === 12'h200) && k < 30);
    chk("mid_second_bcd", 32'(bcd), 32'h200);
    chk("mid_second_time", 32'(k <= 10), 32'd1);
    $display("conv mid value=200 bcd=%03h after=%0d", bcd, k);
    model_last = 200;
    model_bcd  = to_bcd(200);
    sweep("mid", 4 * SCAN_DIV + 1);

    @(negedge clk);
    blank = 1'b1;
    sweep("blank", 5);
    blank = 1'b0;
    sweep("unblank", 2 * SCAN_DIV + 3);

    // Reset in the middle of a conversion, then the same value must convert from scratch.
    value = 8'd99;
    repeat (4) @(negedge clk);
    chk("rstmid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_bcd", 32'(bcd), 32'h000);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_seg", 32'(seg), 32'h7F);
    chk("rstmid_an", 32'(an), 32'hF);
    model_last = 0;
    model_bcd  = 12'h000;
    @(negedge clk);
    rst_n = 1'b1;
    wait_conv(99, "rst99");
    sweep("rst99", 4 * SCAN_DIV + 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
